alu_result_sel_pipe: RTL and testbench
======================================

Name: alu_result_sel_pipe

Overview:
- Parametrised, pipelined N:1 result selector for the MASTER_ALU.
- Picks one of NUM_IN WIDTH-bit functional-unit results by `sel` and registers it behind a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered `in_ready`.
- Flags and counts out-of-range selects instead of propagating X.

Parameters:
- WIDTH, 32, data width of each input and of `out`.
- NUM_IN, 16, number of selectable inputs; legal range 2..2**SEL_W.
- SEL_W, 4, select width; must satisfy 2**SEL_W >= NUM_IN.
- CNT_W, 16, width of the saturating illegal-select counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_bus  input  NUM_IN*WIDTH  concatenated inputs; input k occupies bits [k*WIDTH +: WIDTH], with k=0 selected by sel=0.
- sel  input  SEL_W  input index, sampled with in_bus on acceptance.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept; a registered signal.
- out  output  WIDTH  selected result.
- out_sel  output  SEL_W  the sel value that produced `out`.
- out_err  output  1  the sel value was >= NUM_IN; `out` is 0.
- out_valid  output  1  out, out_sel and out_err are valid.
- out_ready  input  1  consumer accepts.
- err_cnt  output  CNT_W  count of accepted illegal selects; saturates.

Behaviour:
- Reset (async assert, sync release): main and skid entries empty; out_valid=0, in_ready=1, out=0, out_sel=0, out_err=0, err_cnt=0. Reset during a stalled transfer discards both entries.
- Accept: acc = in_valid & in_ready. Release: rel = out_valid & out_ready.
- Entry payload = {data, sel, err}:
  - data = input[sel] when sel < NUM_IN.
  - data = 0 and err = 1 when sel >= NUM_IN.
- Latency: an accept in cycle t appears on the outputs in cycle t+1 when the main entry was empty or released in cycle t.
- Outputs are driven only from the main entry (M). Skid entry S holds overflow.
- Per-cycle update rules:
  - M empty: acc loads M.
  - M full, rel, S empty: M <= new payload if acc, else M becomes empty.
  - M full, rel, S full: M <= S and S empties. acc cannot occur because in_ready=0.
  - M full, no rel, acc: S <= new payload.
  - M full, no rel, no acc: hold.
- in_ready is the registered value of !S_full_next, so in_ready=0 exactly while S holds data.
- Stall rule: while out_valid=1 and out_ready=0, out, out_sel and out_err are stable.
- Ordering is strict FIFO. No payload is dropped or duplicated.
- Sustained throughput is 1 transfer per cycle with out_ready held at 1.
- in_valid with in_ready=0 has no effect. Inputs are not sampled and not counted.
- err_cnt increments by 1 on each acc with sel >= NUM_IN and saturates at 2**CNT_W-1. It never counts unaccepted requests.
- When NUM_IN = 2**SEL_W, out_err is never asserted.
- The block is fully combinational-free from inputs to outputs; in_ready does not depend on out_ready in the same cycle.

Test Plan:
- Reset, then drive NUM_IN=16 inputs with input k = 32'hA000_0000+k, sel=5, in_valid pulsed 1 cycle, out_ready=1 -> next cycle out_valid=1, out=32'hA000_0005, out_sel=5, out_err=0; following cycle out_valid=0.
- Streaming: sel=0..15 on consecutive cycles, out_ready=1 -> outputs 32'hA000_0000..32'hA000_000F in order, one per cycle; in_ready stays 1 throughout.
- Backpressure: stream sel=1,2,3 with out_ready=0 ->
  - out=..01 held stable; in_ready falls to 0 after the second accept; sel=3 is not accepted.
  - Raise out_ready -> outputs ..01, ..02, then ..03 after in_ready returns to 1 and sel=3 is accepted; no loss or duplication.
- Illegal select: NUM_IN=12, SEL_W=4, sel=13 accepted -> out=0, out_sel=13, out_err=1, err_cnt=1. Repeat with in_ready=0 -> err_cnt unchanged.
- Saturation: CNT_W=2, five accepted illegal selects -> err_cnt sequence 1,2,3,3,3.
- Async reset mid-stall: M and S full, assert rst_n=0 between clock edges -> out_valid=0, in_ready=1, err_cnt=0 immediately; after release, the first new accept is output normally.

Source files
------------

// File: rtl/alu_result_sel_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_sel_pipe
// Description : Pipelined N:1 result selector with a 2-entry skid buffer and
//               a saturating illegal-select counter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_sel_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 16,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        err_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [WIDTH-1:0] w_in [NUM_IN];
  logic [WIDTH-1:0] w_data;
  logic             w_err;
  logic             w_acc;
  logic             w_rel;

  // Main entry M drives the outputs; skid entry S absorbs one overflow.
  logic             r_m_valid;
  logic [WIDTH-1:0] r_m_data;
  logic [SEL_W-1:0] r_m_sel;
  logic             r_m_err;
  logic             r_s_valid;
  logic [WIDTH-1:0] r_s_data;
  logic [SEL_W-1:0] r_s_sel;
  logic             r_s_err;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_m_valid_nxt;
  logic [WIDTH-1:0] w_m_data_nxt;
  logic [SEL_W-1:0] w_m_sel_nxt;
  logic             w_m_err_nxt;
  logic             w_s_valid_nxt;
  logic [WIDTH-1:0] w_s_data_nxt;
  logic [SEL_W-1:0] w_s_sel_nxt;
  logic             w_s_err_nxt;

  genvar k;
  generate
    for (k = 0; k < NUM_IN; k++) begin : g_unpack
      assign w_in[k] = in_bus[k*WIDTH +: WIDTH];
    end
  endgenerate

  // Out-of-range selects yield zero data rather than an undefined index.
  always_comb begin
    w_data = '0;
    w_err  = (int'(sel) >= NUM_IN);
    for (int i = 0; i < NUM_IN; i++) begin
      if (int'(sel) == i) begin
        w_data = w_in[i];
      end
    end
  end

  assign w_acc = in_valid & r_in_ready;
  assign w_rel = r_m_valid & out_ready;

  always_comb begin
    w_m_valid_nxt = r_m_valid;
    w_m_data_nxt  = r_m_data;
    w_m_sel_nxt   = r_m_sel;
    w_m_err_nxt   = r_m_err;
    w_s_valid_nxt = r_s_valid;
    w_s_data_nxt  = r_s_data;
    w_s_sel_nxt   = r_s_sel;
    w_s_err_nxt   = r_s_err;
    if (!r_m_valid) begin
      if (w_acc) begin
        w_m_valid_nxt = 1'b1;
        w_m_data_nxt  = w_data;
        w_m_sel_nxt   = sel;
        w_m_err_nxt   = w_err;
      end
    end else if (w_rel) begin
      if (r_s_valid) begin
        // in_ready is low while S is full, so no accept can collide here.
        w_m_data_nxt  = r_s_data;
        w_m_sel_nxt   = r_s_sel;
        w_m_err_nxt   = r_s_err;
        w_s_valid_nxt = 1'b0;
      end else if (w_acc) begin
        w_m_data_nxt  = w_data;
        w_m_sel_nxt   = sel;
        w_m_err_nxt   = w_err;
      end else begin
        w_m_valid_nxt = 1'b0;
      end
    end else if (w_acc) begin
      w_s_valid_nxt = 1'b1;
      w_s_data_nxt  = w_data;
      w_s_sel_nxt   = sel;
      w_s_err_nxt   = w_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_m_sel    <= '0;
      r_m_err    <= 1'b0;
      r_s_valid  <= 1'b0;
      r_s_data   <= '0;
      r_s_sel    <= '0;
      r_s_err    <= 1'b0;
      r_in_ready <= 1'b1;
      r_err_cnt  <= '0;
    end else begin
      r_m_valid  <= w_m_valid_nxt;
      r_m_data   <= w_m_data_nxt;
      r_m_sel    <= w_m_sel_nxt;
      r_m_err    <= w_m_err_nxt;
      r_s_valid  <= w_s_valid_nxt;
      r_s_data   <= w_s_data_nxt;
      r_s_sel    <= w_s_sel_nxt;
      r_s_err    <= w_s_err_nxt;
      r_in_ready <= !w_s_valid_nxt;
      if (w_acc && w_err && (r_err_cnt != c_cnt_max)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out       = r_m_data;
  assign out_sel   = r_m_sel;
  assign out_err   = r_m_err;
  assign out_valid = r_m_valid;
  assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_sel_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_sel_pipe
// Description : Directed table-driven bench for alu_result_sel_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_sel_pipe;

  logic          clk;
  logic          rst_n;
  logic [511:0]  in_bus;
  logic [3:0]    sel;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   out;
  logic [3:0]    out_sel;
  logic          out_err;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   err_cnt;

  logic [383:0]  b_bus;
  logic [3:0]    b_sel;
  logic          b_valid;
  logic          b_in_ready;
  logic [31:0]   b_out;
  logic [3:0]    b_out_sel;
  logic          b_out_err;
  logic          b_out_valid;
  logic          b_out_ready;
  logic [1:0]    b_err_cnt;

  int n_checks;
  int n_fail;

  alu_result_sel_pipe #(.WIDTH(32), .NUM_IN(16), .SEL_W(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_sel(out_sel), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready), .err_cnt(err_cnt)
  );

  alu_result_sel_pipe #(.WIDTH(32), .NUM_IN(12), .SEL_W(4), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_bus(b_bus), .sel(b_sel), .in_valid(b_valid),
    .in_ready(b_in_ready), .out(b_out), .out_sel(b_out_sel), .out_err(b_out_err),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .err_cnt(b_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic        in_valid;
    logic        out_ready;
    logic        exp_valid;
    logic [31:0] exp_out;
    logic [3:0]  exp_sel;
    logic        exp_in_ready;
  } vec_t;

  vec_t tbl[64];
  int   n_tbl;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] s, input logic v, input logic r,
                     input logic ev, input logic [3:0] es, input logic eir);
    tbl[n_tbl].sel          = s;
    tbl[n_tbl].in_valid     = v;
    tbl[n_tbl].out_ready    = r;
    tbl[n_tbl].exp_valid    = ev;
    tbl[n_tbl].exp_out      = 32'hA000_0000 + {28'd0, es};
    tbl[n_tbl].exp_sel      = es;
    tbl[n_tbl].exp_in_ready = eir;
    n_tbl++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic b_step(input logic [3:0] s, input logic v, input logic r);
    b_sel       = s;
    b_valid     = v;
    b_out_ready = r;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_tbl    = 0;
    rst_n    = 1'b0;
    sel      = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    b_sel    = '0;
    b_valid  = 1'b0;
    b_out_ready = 1'b1;
    for (int k = 0; k < 16; k++) in_bus[k*32 +: 32] = 32'hA000_0000 + k;
    for (int k = 0; k < 12; k++) b_bus[k*32 +: 32]  = 32'hA000_0000 + k;

    // single pulse, then idle
    add(4'd5, 1'b1, 1'b1, 1'b1, 4'd5, 1'b1);
    add(4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    // full-rate stream
    for (int i = 0; i < 16; i++) add(4'(i), 1'b1, 1'b1, 1'b1, 4'(i), 1'b1);
    add(4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    // backpressure: 1 into M, 2 into S, 3 refused, then drain
    add(4'd1, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1);
    add(4'd2, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0);
    add(4'd3, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0);
    add(4'd3, 1'b1, 1'b1, 1'b1, 4'd2, 1'b1);
    add(4'd3, 1'b1, 1'b1, 1'b1, 4'd3, 1'b1);
    add(4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_out_sel", 64'(out_sel), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < n_tbl; i++) begin
      sel       = tbl[i].sel;
      in_valid  = tbl[i].in_valid;
      out_ready = tbl[i].out_ready;
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(tbl[i].exp_valid));
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].exp_in_ready));
      if (tbl[i].exp_valid) begin
        chk($sformatf("vec%0d_out", i), 64'(out), 64'(tbl[i].exp_out));
        chk($sformatf("vec%0d_sel", i), 64'(out_sel), 64'(tbl[i].exp_sel));
        chk($sformatf("vec%0d_err", i), 64'(out_err), 64'd0);
      end
      chk($sformatf("vec%0d_cnt", i), 64'(err_cnt), 64'd0);
    end
    in_valid = 1'b0;

    // illegal select on the 12-input instance
    b_step(4'd13, 1'b1, 1'b1);
    chk("ill_valid", 64'(b_out_valid), 64'd1);
    chk("ill_out", 64'(b_out), 64'd0);
    chk("ill_sel", 64'(b_out_sel), 64'd13);
    chk("ill_err", 64'(b_out_err), 64'd1);
    chk("ill_cnt", 64'(b_err_cnt), 64'd1);
    b_step(4'd0, 1'b1, 1'b0);
    chk("ill_stall_rdy", 64'(b_in_ready), 64'd0);
    chk("ill_stall_sel", 64'(b_out_sel), 64'd13);
    b_step(4'd13, 1'b1, 1'b0);
    chk("ill_refused_cnt", 64'(b_err_cnt), 64'd1);
    chk("ill_refused_rdy", 64'(b_in_ready), 64'd0);
    b_step(4'd0, 1'b0, 1'b1);
    chk("ill_drain_out", 64'(b_out), 64'hA000_0000);
    chk("ill_drain_err", 64'(b_out_err), 64'd0);
    chk("ill_drain_cnt", 64'(b_err_cnt), 64'd1);
    b_step(4'd0, 1'b0, 1'b1);
    chk("ill_idle_valid", 64'(b_out_valid), 64'd0);

    // saturation with a 2-bit counter
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("sat_rst_cnt", 64'(b_err_cnt), 64'd0);
    begin
      logic [1:0] exp_seq [5];
      logic [3:0] sel_seq [5];
      exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      sel_seq = '{4'd12, 4'd13, 4'd14, 4'd15, 4'd13};
      for (int i = 0; i < 5; i++) begin
        b_step(sel_seq[i], 1'b1, 1'b1);
        chk($sformatf("sat%0d_cnt", i), 64'(b_err_cnt), 64'(exp_seq[i]));
        chk($sformatf("sat%0d_err", i), 64'(b_out_err), 64'd1);
      end
    end
    b_valid = 1'b0;

    // async reset while both entries are full
    sel = 4'd4; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    sel = 4'd6;
    tick();
    in_valid = 1'b0;
    chk("stall_full_rdy", 64'(in_ready), 64'd0);
    chk("stall_full_out", 64'(out), 64'hA000_0004);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(out_valid), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd1);
    chk("async_cnt", 64'(err_cnt), 64'd0);
    chk("async_b_cnt", 64'(b_err_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sel = 4'd7; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_out", 64'(out), 64'hA000_0007);
    chk("post_rst_sel", 64'(out_sel), 64'd7);
    tick();
    chk("post_rst_idle", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
